// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that adds BPC bits per clock with a carry
// flip-flop between slices. Start/Busy/Done handshake plus signed-overflow flag.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);
    localparam int K  = WIDTH / BPC;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_psum, r_sum;
    logic             r_carry, r_cout, r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [BPC:0]     w_c;
    logic [BPC-1:0]   w_s;
    logic [WIDTH-1:0] w_psum_nxt;
    logic             w_accept, w_last;

    // Ripple of BPC full adders fed by the carry flip-flop
    assign w_c[0] = r_carry;

    generate
        if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and divisible by BPC");
        end
        for (genvar i = 0; i < BPC; i++) begin : g_slice
            serial_adder_fa u_fa (
                .i_a  (r_a[i]),
                .i_b  (r_b[i]),
                .i_ci (w_c[i]),
                .o_s  (w_s[i]),
                .o_co (w_c[i+1])
            );
        end
        // New slice bits enter at the top; after K shifts the LSB slice sits at bit 0
        if (BPC == WIDTH) begin : g_full
            assign w_psum_nxt = w_s;
        end else begin : g_part
            assign w_psum_nxt = {w_s, r_psum[WIDTH-1:BPC]};
        end
    endgenerate

    assign w_last   = (r_cnt == LAST);
    assign w_accept = i_start && (r_state != S_RUN);

    // Next-state logic; DONE accepts a new Start like IDLE for back-to-back use
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Operand capture, per-cycle slice shift, and result load on the last slice
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
            r_psum  <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_carry <= w_c[BPC];
            r_psum  <= w_psum_nxt;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_psum_nxt;
                r_cout <= w_c[BPC];
                // w_c[BPC-1] is the carry entering bit WIDTH-1 on the last slice
                r_ovf  <= w_c[BPC] ^ w_c[BPC-1];
            end
        end
    end

    assign o_busy     = (r_state == S_RUN);
    assign o_done     = (r_state == S_DONE);
    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_overflow = r_ovf;
endmodule

// One-bit full adder, the per-bit cell of a slice
module serial_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule
